// File: rtl/tr_step_arbiter_if.sv
// Tuner stepper-driver bus shared by the manual block, the auto tuning loop
// and the step arbiter.
//
// Request semantics (there is no ready): man_en and auto_req are level
// requests sampled only while the arbiter is idle. A request is accepted when
// grant goes non-zero. An automatic request is retired by a one-cycle
// auto_done pulse, qualified by auto_abort. The requester drops auto_req
// after acceptance and re-asserts it to retry after an abort.
//
// master : request side (man_*, auto_*, half_period, limit out; driver/status in)
// slave  : arbiter side (inverse directions)
interface tr_step_arbiter_if #(
    parameter int WIDTH    = 32,
    parameter int PERIOD_W = 16
);
    logic                man_en;
    logic                man_dir;
    logic                auto_req;
    logic                auto_dir;
    logic [WIDTH-1:0]    auto_steps;
    logic [PERIOD_W-1:0] half_period;
    logic                limit;
    logic                step;
    logic                dir;
    logic                drv_en;
    logic [WIDTH-1:0]    count_N;
    logic [1:0]          grant;
    logic                busy;
    logic                auto_done;
    logic                auto_abort;
    logic                limit_hit;

    modport master (
        output man_en, man_dir, auto_req, auto_dir, auto_steps, half_period, limit,
        input  step, dir, drv_en, count_N, grant, busy, auto_done, auto_abort, limit_hit
    );

    modport slave (
        input  man_en, man_dir, auto_req, auto_dir, auto_steps, half_period, limit,
        output step, dir, drv_en, count_N, grant, busy, auto_done, auto_abort, limit_hit
    );
endinterface

// File: rtl/tr_step_arbiter.sv
// Stepper-motor driver arbiter: shares step/dir/drv_en between the manual
// enable and the automatic tuning loop (manual has priority), generates the
// step pulse train and counts rising step edges in count_N.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : tr_step_arbiter_if.slave (requests in, driver/status out)
//   state_dbg  : current FSM state (IDLE=0, SETUP=1, RUN=2, FINISH=3)
module tr_step_arbiter #(
    parameter int WIDTH     = 32,
    parameter int PERIOD_W  = 16,
    parameter int DIR_SETUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    tr_step_arbiter_if.slave bus,
    output logic [1:0]       state_dbg
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_FINISH} state_t;

    localparam int SC_W = $clog2(DIR_SETUP + 1);
    localparam logic [SC_W-1:0]     SC_LAST = SC_W'(DIR_SETUP - 1);
    localparam logic [SC_W-1:0]     SC_ONE  = SC_W'(1);
    localparam logic [PERIOD_W-1:0] P_ONE   = PERIOD_W'(1);
    localparam logic [WIDTH-1:0]    W_ONE   = WIDTH'(1);

    state_t              state_q, state_n;
    logic                step_q, step_n;
    logic                dir_q, dir_n;
    logic                drv_en_q, drv_en_n;
    logic [WIDTH-1:0]    count_q, count_n;
    logic [WIDTH-1:0]    steps_q, steps_n;
    logic [1:0]          grant_q, grant_n;
    logic                done_q, done_n;
    logic                abort_q, abort_n;
    logic                lim_q, lim_n;
    logic                pre_q, pre_n;      // auto grant was preempted
    logic [PERIOD_W-1:0] hp_q, hp_n;
    logic [PERIOD_W-1:0] phase_q, phase_n;
    logic [SC_W-1:0]     sc_q, sc_n;
    logic                phase_tc;

    assign phase_tc = (phase_q == hp_q - P_ONE);

    always_comb begin
        state_n  = state_q;
        step_n   = step_q;
        dir_n    = dir_q;
        drv_en_n = drv_en_q;
        count_n  = count_q;
        steps_n  = steps_q;
        grant_n  = grant_q;
        done_n   = 1'b0;
        abort_n  = 1'b0;
        lim_n    = 1'b0;
        pre_n    = pre_q;
        hp_n     = hp_q;
        phase_n  = phase_q;
        sc_n     = sc_q;

        case (state_q)
            S_IDLE: begin
                if (!bus.limit) begin
                    if (bus.man_en || (bus.auto_req && (bus.auto_steps != '0))) begin
                        state_n  = S_SETUP;
                        grant_n  = bus.man_en ? 2'b01 : 2'b10;
                        dir_n    = bus.man_en ? bus.man_dir : bus.auto_dir;
                        steps_n  = bus.auto_steps;
                        hp_n     = (bus.half_period == '0) ? P_ONE : bus.half_period;
                        drv_en_n = 1'b1;
                        count_n  = '0;
                        sc_n     = '0;
                        phase_n  = '0;
                        step_n   = 1'b0;
                        pre_n    = 1'b0;
                    end else if (bus.auto_req) begin
                        // zero-length move completes immediately
                        done_n = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (sc_q == SC_LAST) begin
                    state_n = S_RUN;
                    phase_n = '0;
                end else begin
                    sc_n = sc_q + SC_ONE;
                end
            end
            S_RUN: begin
                if (phase_tc) begin
                    phase_n = '0;
                    step_n  = !step_q;
                    if (!step_q) count_n = count_q + W_ONE;
                end else begin
                    phase_n = phase_q + P_ONE;
                end
                if (grant_q[0]) begin
                    if (!bus.man_en) state_n = S_FINISH;
                end else if (phase_tc && !step_q && (count_q + W_ONE == steps_q)) begin
                    state_n = S_FINISH;
                end else if (phase_tc && step_q && bus.man_en) begin
                    // preempt only on a falling boundary so no pulse is cut
                    state_n = S_FINISH;
                    pre_n   = 1'b1;
                end
            end
            S_FINISH: begin
                if (step_q) begin
                    if (phase_tc) begin
                        step_n  = 1'b0;
                        phase_n = '0;
                    end else begin
                        phase_n = phase_q + P_ONE;
                    end
                end else begin
                    state_n  = S_IDLE;
                    grant_n  = 2'b00;
                    drv_en_n = 1'b0;
                    if (grant_q[1]) begin
                        done_n  = 1'b1;
                        abort_n = pre_q;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // endstop overrides everything in an active grant; count_N freezes
        if ((state_q != S_IDLE) && bus.limit) begin
            state_n  = S_IDLE;
            step_n   = 1'b0;
            grant_n  = 2'b00;
            drv_en_n = 1'b0;
            count_n  = count_q;
            lim_n    = 1'b1;
            done_n   = grant_q[1];
            abort_n  = grant_q[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            drv_en_q <= 1'b0;
            count_q  <= '0;
            steps_q  <= '0;
            grant_q  <= 2'b00;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            lim_q    <= 1'b0;
            pre_q    <= 1'b0;
            hp_q     <= P_ONE;
            phase_q  <= '0;
            sc_q     <= '0;
        end else begin
            state_q  <= state_n;
            step_q   <= step_n;
            dir_q    <= dir_n;
            drv_en_q <= drv_en_n;
            count_q  <= count_n;
            steps_q  <= steps_n;
            grant_q  <= grant_n;
            done_q   <= done_n;
            abort_q  <= abort_n;
            lim_q    <= lim_n;
            pre_q    <= pre_n;
            hp_q     <= hp_n;
            phase_q  <= phase_n;
            sc_q     <= sc_n;
        end
    end

    assign bus.step       = step_q;
    assign bus.dir        = dir_q;
    assign bus.drv_en     = drv_en_q;
    assign bus.count_N    = count_q;
    assign bus.grant      = grant_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.auto_done  = done_q;
    assign bus.auto_abort = abort_q;
    assign bus.limit_hit  = lim_q;
    assign state_dbg      = state_q;
endmodule

// File: doc/tr_step_arbiter.md
Name: tr_step_arbiter

Overview:
- Owns the single tuner stepper-motor (ШД) driver interface: step, dir and driver enable.
- Shares that interface between the manual-mode enable and the automatic tuning loop's step requests.
- Generates the step pulse train and counts issued pulses in count_N, which is fed back to the manual-mode block for its pulse-number comparison.
- Manual requests have priority over automatic requests.

Parameters:
WIDTH, 32, width of pulse counter, auto_steps and count_N
PERIOD_W, 16, width of half_period
DIR_SETUP, 4, clk cycles dir is held stable with step=0 before the first step of a grant (≥1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
man_en  in  1  manual-mode enable (level); request held while high
man_dir  in  1  manual direction
auto_req  in  1  automatic move request (level, sampled in IDLE)
auto_dir  in  1  automatic direction
auto_steps  in  WIDTH  number of steps for automatic move
half_period  in  PERIOD_W  step half-period in clk cycles; 0 treated as 1
limit  in  1  endstop / abort, level
step  out  1  step pulse to driver
dir  out  1  direction to driver
drv_en  out  1  driver enable
count_N  out  WIDTH  rising step edges issued in current/last grant
grant  out  2  one-hot {auto, manual}; 0 when idle
busy  out  1  state ≠ IDLE
auto_done  out  1  1-cycle pulse: automatic move ended
auto_abort  out  1  valid with auto_done: 1 = ended early (preempted or limit)
limit_hit  out  1  1-cycle pulse when limit aborts a grant

Behaviour:
- Reset: all outputs 0; state IDLE; count_N=0.
- States: IDLE, SETUP, RUN, FINISH.
- IDLE, limit=0:
  - man_en → SETUP, grant=01, dir←man_dir.
  - else auto_req with auto_steps≠0 → SETUP, grant=10, dir←auto_dir.
  - auto_req with auto_steps=0 → auto_done=1, auto_abort=0 next cycle; stays IDLE; no pulses.
  - limit=1 blocks all grants.
- Entry values latched on leaving IDLE: dir, half_period (0→1) and auto_steps. Input changes during a grant are ignored.
- SETUP: count_N cleared on entry. step=0, drv_en=1 for exactly DIR_SETUP cycles, then → RUN.
- RUN pulse generation:
  - Phase counter runs 0..hp-1. At terminal count, step toggles; first toggle is 0→1.
  - A step is hp cycles high followed by hp cycles low.
  - count_N increments in the same cycle step goes 0→1.
  - The first rising edge occurs hp cycles after RUN entry.
- RUN, manual grant: continues while man_en=1. man_en=0 → FINISH.
- RUN, auto grant:
  - After the rising edge that makes count_N=auto_steps, → FINISH.
  - man_en=1 preempts at the next step-falling boundary (step 1→0) → FINISH, auto_abort=1.
- FINISH:
  - If step=1, hold until the high half completes, then step=0.
  - Then → IDLE; grant=0, drv_en=0.
  - For an auto grant, auto_done pulses in the IDLE-entry cycle.
  - A preempted auto request is not re-queued; the requester re-asserts auto_req.
- limit=1 in SETUP/RUN/FINISH:
  - Next cycle: step=0 (pulse truncated), state IDLE, grant=0, drv_en=0, limit_hit=1.
  - For an auto grant, auto_done=1 and auto_abort=1.
- count_N holds its last value in IDLE until the next SETUP entry. It is never cleared by grant end.
- count_N wraps modulo 2^WIDTH with no saturation.
- Simultaneous man_en and auto_req in IDLE: manual wins.
- After any grant ends, IDLE lasts at least 1 cycle before a new grant.
- rst mid-operation: immediate return to reset values next edge; no auto_done.

Test Plan:
- Manual grant:
  - Stimulus: half_period=3, man_en=1 for 40 cycles, then 0.
  - Required: grant=01; DIR_SETUP=4 cycles with step=0; rising edges every 6 cycles, first 3 cycles after RUN entry.
  - Required at release: the pulse in progress completes its high half; count_N equals the number of rising edges issued.
- Auto move:
  - Stimulus: auto_steps=5, half_period=2.
  - Required: exactly 5 pulses (2 high / 2 low); count_N=5; auto_done=1 with auto_abort=0 one cycle after the final falling edge; grant returns to 0.
- Zero steps:
  - Stimulus: auto_steps=0, auto_req=1.
  - Required: auto_done=1 next cycle; step never toggles; drv_en stays 0.
- Preemption:
  - Stimulus: auto_steps=100 running; man_en rises after count_N=3.
  - Required: auto ends at the next falling edge with auto_done=1, auto_abort=1; one IDLE cycle; then grant=01 with count_N cleared in SETUP.
- Limit abort:
  - Stimulus: limit=1 asserted while step=1 during an auto move.
  - Required: step=0, drv_en=0 next cycle; limit_hit, auto_done and auto_abort each pulse once; no new grant while limit=1.
- Edge cases:
  - half_period=0: behaves as 1, i.e. a 2-cycle step period.
  - rst asserted mid-RUN: all outputs 0 on the next cycle.
